mult_div_unit: RTL and testbench

//  Iterative multiply/divide unit for the MIPS datapath (MULT, MULTU, DIV, DIVU, MTHI, MTLO).

---
 rtl/mult_div_unit.sv | 124 ++++++++++++
 tb/tb_mult_div_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Purpose: iterative MULT/MULTU/DIV/DIVU with MTHI/MTLO, producing the HI/LO pair.
// Latency: WIDTH+1 edges from the accepting edge to Pronto; Hi/Lo update on the Pronto edge.
// Backpressure: none; Ocupado stalls the issuer, and Inicio/EscHi/EscLo are ignored while busy.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Inicio,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             EscHi,
    input  logic             EscLo,
    input  logic [WIDTH-1:0] Entrada,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Ocupado,
    output logic             Pronto,
    output logic             DivZero
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               dz;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      count;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [2*WIDTH-1:0] prod_fix;

    always_comb begin
        abs_a     = (Op[0] && A[WIDTH-1]) ? -A : A;
        abs_b     = (Op[0] && B[WIDTH-1]) ? -B : B;
        // multiply: acc = {partial product, remaining multiplier bits}
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        // divide: acc = {partial remainder, dividend bits still to shift in}
        div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};
        quo_fix   = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix   = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        prod_fix  = neg_q ? -acc : acc;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= IDLE;
            Hi      <= '0;
            Lo      <= '0;
            Ocupado <= 1'b0;
            Pronto  <= 1'b0;
            DivZero <= 1'b0;
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dz      <= 1'b0;
            a_raw   <= '0;
            opnd    <= '0;
            acc     <= '0;
            count   <= '0;
        end else begin
            Pronto  <= 1'b0;
            DivZero <= 1'b0;
            case (state)
                IDLE: begin
                    if (Inicio) begin
                        is_div  <= Op[1];
                        neg_q   <= Op[0] & (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_r   <= Op[0] & A[WIDTH-1];
                        dz      <= Op[1] && (B == '0);
                        a_raw   <= A;
                        opnd    <= Op[1] ? abs_b : abs_a;
                        acc     <= {{WIDTH{1'b0}}, (Op[1] ? abs_a : abs_b)};
                        count   <= '0;
                        Ocupado <= 1'b1;
                        state   <= CALC;
                    end else begin
                        if (EscHi) Hi <= Entrada;
                        if (EscLo) Lo <= Entrada;
                    end
                end
                CALC: begin
                    if (is_div) begin
                        if (!div_trial[WIDTH])
                            acc <= {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                        else
                            acc <= {acc[2*WIDTH-2:0], 1'b0};
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    if (dz) begin
                        Hi      <= a_raw;
                        Lo      <= '1;
                        DivZero <= 1'b1;
                    end else if (is_div) begin
                        Hi <= rem_fix;
                        Lo <= quo_fix;
                    end else begin
                        {Hi, Lo} <= prod_fix;
                    end
                    Pronto  <= 1'b1;
                    Ocupado <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed operations queue expected Hi/Lo/DivZero,
// a negedge monitor pops and compares whenever Pronto is seen.
module tb_mult_div_unit;
    logic        Clk = 1'b0;
    logic        Rst;
    logic        Inicio;
    logic [1:0]  Op;
    logic [31:0] A, B, Entrada;
    logic        EscHi, EscLo;
    logic [31:0] Hi, Lo;
    logic        Ocupado, Pronto, DivZero;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    mult_div_unit #(.WIDTH(32)) dut (
        .Clk(Clk), .Rst(Rst), .Inicio(Inicio), .Op(Op), .A(A), .B(B),
        .EscHi(EscHi), .EscLo(EscLo), .Entrada(Entrada),
        .Hi(Hi), .Lo(Lo), .Ocupado(Ocupado), .Pronto(Pronto), .DivZero(DivZero)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // monitor: every Pronto must match the oldest outstanding operation
    always @(negedge Clk) begin
        exp_t e;
        if (Rst === 1'b0) begin
            if (Pronto) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pronto actual=1 required=0 (Hi=%h Lo=%h)", Hi, Lo);
                end else begin
                    e = sb.pop_front();
                    chk("hi", Hi, e.hi);
                    chk("lo", Lo, e.lo);
                    chk("divzero", 32'(DivZero), 32'(e.dz));
                    chk("latency", 32'(cyc - e.cyc), 32'd33);
                    chk("ocupado_clear", 32'(Ocupado), 32'd0);
                end
            end else if (DivZero) begin
                checks++;
                errors++;
                $display("FAIL divzero_without_pronto actual=1 required=0");
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                         input bit b2b);
        exp_t e;
        if (!b2b) @(negedge Clk);
        Inicio = 1'b1;
        Op = op;
        A = a;
        B = b;
        @(posedge Clk);
        #1;
        e.hi = ehi;
        e.lo = elo;
        e.dz = edz;
        e.cyc = cyc;
        sb.push_back(e);
        Inicio = 1'b0;
        Op = 2'($urandom);
        A = $urandom;
        B = $urandom;
        chk("ocupado_set", 32'(Ocupado), 32'd1);
    endtask

    task automatic wait_done();
        bit done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge Clk);
            #1;
            if (sb.size() == 0) done = 1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout actual=%0d_pending required=0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        Rst = 1'b1; Inicio = 1'b0; Op = 2'b00; A = '0; B = '0;
        EscHi = 1'b0; EscLo = 1'b0; Entrada = '0;
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;
        @(negedge Clk);
        chk("rst_hi", Hi, 32'h0);
        chk("rst_lo", Lo, 32'h0);
        chk("rst_ocupado", 32'(Ocupado), 32'd0);
        chk("rst_pronto", 32'(Pronto), 32'd0);

        issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 0); wait_done();
        issue(2'b01, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 0); wait_done();
        issue(2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 0); wait_done();
        issue(2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0); wait_done();
        issue(2'b10, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 0); wait_done();
        // back-to-back: each issue lands on the edge right after the previous Pronto
        issue(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0, 1); wait_done();
        issue(2'b01, 32'hFFFFFFFC, 32'hFFFFFFFB, 32'h0,        32'd20,       1'b0, 1); wait_done();
        issue(2'b11, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 1); wait_done();
        issue(2'b00, 32'h12345678, 32'h10,       32'h1,        32'h23456780, 1'b0, 1); wait_done();
        issue(2'b11, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 1); wait_done();

        // MTHI/MTLO in idle
        @(negedge Clk);
        EscHi = 1'b1; EscLo = 1'b1; Entrada = 32'hAAAA5555;
        @(posedge Clk); #1;
        EscHi = 1'b0; EscLo = 1'b0;
        chk("mthi_both", Hi, 32'hAAAA5555);
        chk("mtlo_both", Lo, 32'hAAAA5555);
        @(negedge Clk);
        EscLo = 1'b1; Entrada = 32'h00001234;
        @(posedge Clk); #1;
        EscLo = 1'b0;
        chk("mtlo_only_lo", Lo, 32'h00001234);
        chk("mtlo_only_hi", Hi, 32'hAAAA5555);

        // Inicio wins over EscHi on the same edge; writes and starts while busy are ignored
        @(negedge Clk);
        EscHi = 1'b1; Entrada = 32'hDEADBEEF;
        issue(2'b00, 32'd3, 32'd5, 32'h0, 32'd15, 1'b0, 1);
        repeat (5) @(negedge Clk);
        chk("busy_hi_held", Hi, 32'hAAAA5555);
        chk("busy_lo_held", Lo, 32'h00001234);
        Inicio = 1'b1; EscLo = 1'b1;
        @(negedge Clk);
        Inicio = 1'b0; EscHi = 1'b0; EscLo = 1'b0;
        chk("busy_ocupado", 32'(Ocupado), 32'd1);
        wait_done();
        repeat (40) @(negedge Clk);
        chk("result_held_hi", Hi, 32'h0);
        chk("result_held_lo", Lo, 32'd15);

        // reset mid-operation aborts without a result
        issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 0);
        repeat (10) @(negedge Clk);
        Rst = 1'b1;
        sb.delete();
        @(posedge Clk); #1;
        Rst = 1'b0;
        @(negedge Clk);
        chk("abort_hi", Hi, 32'h0);
        chk("abort_lo", Lo, 32'h0);
        chk("abort_ocupado", 32'(Ocupado), 32'd0);
        chk("abort_pronto", 32'(Pronto), 32'd0);
        repeat (40) @(negedge Clk);
        chk("abort_idle_ocupado", 32'(Ocupado), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
